// File: rtl/logic_sweep_ctrl.sv
// Sweep sequencer and self-checker for the two-input logic unit (out1 = in1 ^ in2, out2 = ~in2).
// It drives all four input vectors per pass, samples after a settle time, and reports the result.
module logic_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             dut_in1,
    output logic             dut_in2,
    input  logic             dut_out1,
    input  logic             dut_out2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_err_vec,
    output logic             first_err_vld
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       vec;
    logic [1:0]       vec_nxt;
    logic [PW-1:0]    pass_idx;
    logic [PW-1:0]    pass_idx_nxt;
    logic [SW-1:0]    settle;
    logic [SW-1:0]    settle_nxt;
    logic [1:0]       in_nxt;
    logic             done_nxt;
    logic             pass_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic [ERR_W-1:0] err_inc;
    logic [1:0]       fev_nxt;
    logic             fvld_nxt;
    logic             exp_out1;
    logic             exp_out2;
    logic             mismatch;
    logic             last_vec;

    assign busy     = (state != IDLE);
    assign exp_out1 = vec[1] ^ vec[0];
    assign exp_out2 = ~vec[0];
    assign mismatch = (dut_out1 != exp_out1) || (dut_out2 != exp_out2);
    assign err_inc  = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + 1'b1;
    assign last_vec = (vec == 2'd3) && (pass_idx == PW'(PASSES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            vec           <= 2'd0;
            pass_idx      <= '0;
            settle        <= '0;
            dut_in1       <= 1'b0;
            dut_in2       <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vec <= 2'd0;
            first_err_vld <= 1'b0;
        end else begin
            state         <= state_nxt;
            vec           <= vec_nxt;
            pass_idx      <= pass_idx_nxt;
            settle        <= settle_nxt;
            dut_in1       <= in_nxt[1];
            dut_in2       <= in_nxt[0];
            done          <= done_nxt;
            pass          <= pass_nxt;
            err_count     <= err_nxt;
            first_err_vec <= fev_nxt;
            first_err_vld <= fvld_nxt;
        end
    end

    // The unit inputs are loaded on entry to DRIVE so each vector settles for the full hold time.
    always_comb begin
        state_nxt    = state;
        vec_nxt      = vec;
        pass_idx_nxt = pass_idx;
        settle_nxt   = settle;
        in_nxt       = {dut_in1, dut_in2};
        done_nxt     = 1'b0;
        pass_nxt     = pass;
        err_nxt      = err_count;
        fev_nxt      = first_err_vec;
        fvld_nxt     = first_err_vld;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = DRIVE;
                    vec_nxt      = 2'd0;
                    pass_idx_nxt = '0;
                    settle_nxt   = '0;
                    in_nxt       = 2'd0;
                    pass_nxt     = 1'b0;
                    err_nxt      = '0;
                    fev_nxt      = 2'd0;
                    fvld_nxt     = 1'b0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    in_nxt    = 2'd0;
                end else if (settle == SW'(SETTLE_CYCLES - 1)) begin
                    state_nxt  = CHECK;
                    settle_nxt = '0;
                end else begin
                    settle_nxt = settle + 1'b1;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_nxt = IDLE;
                    in_nxt    = 2'd0;
                end else begin
                    if (mismatch) begin
                        err_nxt = err_inc;
                        if (!first_err_vld) begin
                            fev_nxt  = vec;
                            fvld_nxt = 1'b1;
                        end
                    end
                    if (last_vec) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_nxt == '0);
                        in_nxt    = 2'd0;
                    end else begin
                        state_nxt  = DRIVE;
                        vec_nxt    = vec + 2'd1;
                        settle_nxt = '0;
                        in_nxt     = vec + 2'd1;
                        if (vec == 2'd3) begin
                            pass_idx_nxt = pass_idx + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                in_nxt    = 2'd0;
            end
            default: begin
                state_nxt = IDLE;
                in_nxt    = 2'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Directed bench for logic_sweep_ctrl: a table of faulty-unit sweeps plus hand-written
// sequences for abort, mid-sweep reset, start during DONE and a saturating multi-pass sweep.
module tb_logic_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_a, abort_a, start_b, abort_b;
    logic       in1_a, in2_a, out1_a, out2_a;
    logic       in1_b, in2_b, out1_b, out2_b;
    logic       busy_a, done_a, pass_a, fvld_a;
    logic       busy_b, done_b, pass_b, fvld_b;
    logic [3:0] err_a;
    logic [2:0] err_b;
    logic [1:0] fev_a, fev_b;
    int         fault_a, fault_b;

    int checks;
    int failures;

    typedef struct {
        string      name;
        int         fault;
        int         exp_err;
        logic [1:0] exp_fev;
        logic       exp_fvld;
        logic       exp_pass;
    } sweep_vec_t;

    sweep_vec_t table_a[6];

    logic_sweep_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .dut_in1(in1_a), .dut_in2(in2_a), .dut_out1(out1_a), .dut_out2(out2_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_vec(fev_a), .first_err_vld(fvld_a)
    );

    logic_sweep_ctrl #(.SETTLE_CYCLES(4), .PASSES(3), .ERR_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .dut_in1(in1_b), .dut_in2(in2_b), .dut_out1(out1_b), .dut_out2(out2_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_vec(fev_b), .first_err_vld(fvld_b)
    );

    // Unit model with selectable faults: 0 good, 1 out1 stuck 0, 2 out2 missing inversion,
    // 3 out1 stuck 1, 4 out2 stuck 0, 5 out1 computed as OR.
    function automatic logic [1:0] unit_model(input int fault, input logic a, input logic b);
        logic o1;
        logic o2;
        o1 = a ^ b;
        o2 = ~b;
        case (fault)
            1: o1 = 1'b0;
            2: o2 = b;
            3: o1 = 1'b1;
            4: o2 = 1'b0;
            5: o1 = a | b;
            default: ;
        endcase
        return {o1, o2};
    endfunction

    assign {out1_a, out2_a} = unit_model(fault_a, in1_a, in2_a);
    assign {out1_b, out2_b} = unit_model(fault_b, in1_b, in2_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulses start on instance A (sampled at edge 0) and follows the sweep until it is idle again.
    task automatic apply_stimulus(input int max_cyc, output int done_cyc, output int done_cnt,
                                  output int seq_ok);
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        done_cyc = -1;
        done_cnt = 0;
        seq_ok   = 1;
        for (int c = 1; c <= max_cyc; c++) begin
            if (c > 1) step();
            if (done_a) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c <= 20 && {in1_a, in2_a} != 2'(((c - 1) / 5) % 4)) seq_ok = 0;
            if (c == 21 && {in1_a, in2_a} != 2'd0) seq_ok = 0;
            if (c <= 21 && !busy_a) seq_ok = 0;
            if (done_cyc > 0 && c > done_cyc) break;
        end
    endtask

    initial begin
        int done_cyc, done_cnt, seq_ok;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start_a  = 1'b0;
        abort_a  = 1'b0;
        start_b  = 1'b0;
        abort_b  = 1'b0;
        fault_a  = 0;
        fault_b  = 0;

        table_a[0] = '{"good",        0, 0, 2'b00, 1'b0, 1'b1};
        table_a[1] = '{"out1_stuck0", 1, 2, 2'b01, 1'b1, 1'b0};
        table_a[2] = '{"out2_noinv",  2, 4, 2'b00, 1'b1, 1'b0};
        table_a[3] = '{"out1_stuck1", 3, 2, 2'b00, 1'b1, 1'b0};
        table_a[4] = '{"out2_stuck0", 4, 2, 2'b00, 1'b1, 1'b0};
        table_a[5] = '{"out1_or",     5, 1, 2'b11, 1'b1, 1'b0};

        repeat (3) step();
        check_output("reset_busy", int'(busy_a), 0);
        check_output("reset_done", int'(done_a), 0);
        check_output("reset_pass", int'(pass_a), 0);
        check_output("reset_err", int'(err_a), 0);
        check_output("reset_fvld", int'(fvld_a), 0);
        check_output("reset_dut_in", int'({in1_a, in2_a}), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            fault_a = table_a[i].fault;
            apply_stimulus(40, done_cyc, done_cnt, seq_ok);
            $display("[TB] sweep %s done at cycle %0d", table_a[i].name, done_cyc);
            check_output({table_a[i].name, "_done_cycle"}, done_cyc, 21);
            check_output({table_a[i].name, "_done_pulses"}, done_cnt, 1);
            check_output({table_a[i].name, "_vector_seq"}, seq_ok, 1);
            check_output({table_a[i].name, "_err"}, int'(err_a), table_a[i].exp_err);
            check_output({table_a[i].name, "_fev"}, int'(fev_a), int'(table_a[i].exp_fev));
            check_output({table_a[i].name, "_fvld"}, int'(fvld_a), int'(table_a[i].exp_fvld));
            check_output({table_a[i].name, "_pass"}, int'(pass_a), int'(table_a[i].exp_pass));
            check_output({table_a[i].name, "_idle"}, int'(busy_a), 0);
            repeat (3) step();
            check_output({table_a[i].name, "_pass_held"}, int'(pass_a), int'(table_a[i].exp_pass));
        end

        // Three passes with out2 wrong: 12 mismatches saturate a 3-bit counter.
        fault_b = 2;
        start_b = 1'b1;
        step();
        start_b  = 1'b0;
        done_cyc = -1;
        done_cnt = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) step();
            if (done_b) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc > 0 && c > done_cyc) break;
        end
        check_output("multi_done_cycle", done_cyc, 61);
        check_output("multi_done_pulses", done_cnt, 1);
        check_output("multi_err_sat", int'(err_b), 7);
        check_output("multi_fev", int'(fev_b), 0);
        check_output("multi_fvld", int'(fvld_b), 1);
        check_output("multi_pass", int'(pass_b), 0);

        // Abort at cycle 8 with stray starts at cycles 3 and 6; one error already logged.
        fault_a = 2;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            step();
            start_a = (c == 3 || c == 6);
        end
        check_output("abort_no_restart_vec", int'({in1_a, in2_a}), 1);
        check_output("abort_busy_before", int'(busy_a), 1);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check_output("abort_busy", int'(busy_a), 0);
        check_output("abort_dut_in", int'({in1_a, in2_a}), 0);
        check_output("abort_err_kept", int'(err_a), 1);
        check_output("abort_fvld_kept", int'(fvld_a), 1);
        check_output("abort_fev_kept", int'(fev_a), 0);
        check_output("abort_pass", int'(pass_a), 0);
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (done_a || busy_a) done_cnt++;
        end
        check_output("abort_stays_quiet", done_cnt, 0);

        // Abort in the final CHECK cycle beats the transition to DONE.
        fault_a = 0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 2; c <= 20; c++) step();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check_output("abort_last_done", int'(done_a), 0);
        check_output("abort_last_busy", int'(busy_a), 0);
        check_output("abort_last_pass", int'(pass_a), 0);

        // Start held through DONE is ignored there and accepted once back in IDLE.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 2; c <= 21; c++) step();
        check_output("done_cycle_seen", int'(done_a), 1);
        start_a = 1'b1;
        step();
        check_output("start_in_done_ignored", int'(busy_a), 0);
        check_output("pass_after_good", int'(pass_a), 1);
        step();
        start_a = 1'b0;
        check_output("start_in_idle_taken", int'(busy_a), 1);
        check_output("pass_cleared_on_start", int'(pass_a), 0);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;

        // Start and abort together in IDLE: start wins.
        start_a = 1'b1;
        abort_a = 1'b1;
        step();
        start_a = 1'b0;
        abort_a = 1'b0;
        check_output("start_beats_abort", int'(busy_a), 1);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;

        // Reset at cycle 10 mid-sweep, then a clean sweep.
        fault_a = 2;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 2; c <= 10; c++) step();
        rst_n = 1'b0;
        step();
        check_output("midreset_busy", int'(busy_a), 0);
        check_output("midreset_err", int'(err_a), 0);
        check_output("midreset_fvld", int'(fvld_a), 0);
        check_output("midreset_dut_in", int'({in1_a, in2_a}), 0);
        check_output("midreset_done", int'(done_a), 0);
        rst_n   = 1'b1;
        fault_a = 0;
        step();
        apply_stimulus(40, done_cyc, done_cnt, seq_ok);
        check_output("after_reset_done_cycle", done_cyc, 21);
        check_output("after_reset_pass", int'(pass_a), 1);
        check_output("after_reset_err", int'(err_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
